// File: rtl/up_ipif_arb_if.sv
// up_ipif_arb_if: bundle of all handshake/bus signals around up_ipif_arb.
//   m0_* / m1_* : upstream master request ports (word addresses, one-cycle req/ack pulses)
//   up_*        : shared port toward the register bank
//   *_timeout   : one-cycle pulse when a response was forced by the wait timeout
// Modport slave is the arbiter's view; modport master is the surrounding environment
// (upstream masters plus register bank).
interface up_ipif_arb_if #(
  parameter int unsigned C_ADDR_WIDTH = 12,
  parameter int unsigned C_DATA_WIDTH = 32
);
  localparam int unsigned AW = C_ADDR_WIDTH - 2;
  localparam int unsigned DW = C_DATA_WIDTH;

  logic [AW-1:0] m0_up_wr_addr;
  logic          m0_up_wr_req;
  logic [3:0]    m0_up_wr_be;
  logic [DW-1:0] m0_up_wr_din;
  logic          m0_up_wr_ack;
  logic [AW-1:0] m0_up_rd_addr;
  logic          m0_up_rd_req;
  logic [DW-1:0] m0_up_rd_dout;
  logic          m0_up_rd_ack;

  logic [AW-1:0] m1_up_wr_addr;
  logic          m1_up_wr_req;
  logic [3:0]    m1_up_wr_be;
  logic [DW-1:0] m1_up_wr_din;
  logic          m1_up_wr_ack;
  logic [AW-1:0] m1_up_rd_addr;
  logic          m1_up_rd_req;
  logic [DW-1:0] m1_up_rd_dout;
  logic          m1_up_rd_ack;

  logic [AW-1:0] up_wr_addr;
  logic          up_wr_req;
  logic [3:0]    up_wr_be;
  logic [DW-1:0] up_wr_din;
  logic          up_wr_ack;
  logic [AW-1:0] up_rd_addr;
  logic          up_rd_req;
  logic [DW-1:0] up_rd_dout;
  logic          up_rd_ack;

  logic          wr_timeout;
  logic          rd_timeout;

  modport slave (
    input  m0_up_wr_addr, m0_up_wr_req, m0_up_wr_be, m0_up_wr_din,
    input  m0_up_rd_addr, m0_up_rd_req,
    output m0_up_wr_ack, m0_up_rd_dout, m0_up_rd_ack,
    input  m1_up_wr_addr, m1_up_wr_req, m1_up_wr_be, m1_up_wr_din,
    input  m1_up_rd_addr, m1_up_rd_req,
    output m1_up_wr_ack, m1_up_rd_dout, m1_up_rd_ack,
    output up_wr_addr, up_wr_req, up_wr_be, up_wr_din,
    input  up_wr_ack,
    output up_rd_addr, up_rd_req,
    input  up_rd_dout, up_rd_ack,
    output wr_timeout, rd_timeout
  );

  modport master (
    output m0_up_wr_addr, m0_up_wr_req, m0_up_wr_be, m0_up_wr_din,
    output m0_up_rd_addr, m0_up_rd_req,
    input  m0_up_wr_ack, m0_up_rd_dout, m0_up_rd_ack,
    output m1_up_wr_addr, m1_up_wr_req, m1_up_wr_be, m1_up_wr_din,
    output m1_up_rd_addr, m1_up_rd_req,
    input  m1_up_wr_ack, m1_up_rd_dout, m1_up_rd_ack,
    input  up_wr_addr, up_wr_req, up_wr_be, up_wr_din,
    output up_wr_ack,
    input  up_rd_addr, up_rd_req,
    output up_rd_dout, up_rd_ack,
    input  wr_timeout, rd_timeout
  );
endinterface

// File: rtl/up_ipif_arb.sv
// up_ipif_arb: two-master arbiter in front of a single register-bank port.
//   aclk   : clock, all logic rising-edge
//   areset : asynchronous active-high reset
//   bus    : up_ipif_arb_if.slave -- master request ports, shared bank port, timeout pulses
// The write and read channels are two identical, independent arbiters (channel 0 = write,
// channel 1 = read). Each channel keeps one pending request per master, grants round-robin,
// issues a one-cycle up_req, waits for up_ack or a timeout, then returns a one-cycle ack.
module up_ipif_arb #(
  parameter int unsigned C_ADDR_WIDTH = 12,
  parameter int unsigned C_DATA_WIDTH = 32,
  parameter int unsigned C_TIMEOUT    = 255
) (
  input logic          aclk,
  input logic          areset,
  up_ipif_arb_if.slave bus
);
  localparam int unsigned AW = C_ADDR_WIDTH - 2;
  localparam int unsigned DW = C_DATA_WIDTH;
  localparam int unsigned PW = AW + 4 + DW;
  localparam int unsigned CW = 16;
  // Leaving WAIT when the counter would step onto C_TIMEOUT gives exactly C_TIMEOUT WAIT cycles.
  localparam logic [CW-1:0] ToLast = CW'(C_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  // Per-channel views of the bus; payload is {addr, be, din}, read channel has be/din zero.
  logic [1:0]    req_in  [2];
  logic [PW-1:0] pay_in  [2][2];
  logic [1:0]    bank_ack;
  logic [PW-1:0] pay_out [2];
  logic [1:0]    m_ack   [2];
  logic [1:0]    up_req;
  logic [1:0]    timeout;
  logic [1:0]    resp_enter;
  logic [1:0]    resp_to;
  logic [1:0]    gnt;

  assign req_in[0]    = {bus.m1_up_wr_req, bus.m0_up_wr_req};
  assign req_in[1]    = {bus.m1_up_rd_req, bus.m0_up_rd_req};
  assign pay_in[0][0] = {bus.m0_up_wr_addr, bus.m0_up_wr_be, bus.m0_up_wr_din};
  assign pay_in[0][1] = {bus.m1_up_wr_addr, bus.m1_up_wr_be, bus.m1_up_wr_din};
  assign pay_in[1][0] = {bus.m0_up_rd_addr, 4'b0000, {DW{1'b0}}};
  assign pay_in[1][1] = {bus.m1_up_rd_addr, 4'b0000, {DW{1'b0}}};
  assign bank_ack     = {bus.up_rd_ack, bus.up_wr_ack};

  for (genvar c = 0; c < 2; c++) begin : g_chan
    state_e          state_q, state_d;
    logic [1:0]      pend_q, pend_d;
    logic [PW-1:0]   lat_q [2];
    logic [PW-1:0]   lat_d [2];
    logic [PW-1:0]   out_q, out_d;
    logic            gnt_q, gnt_d;
    logic            last_q, last_d;
    logic            to_q, to_d;
    logic            sel;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      lat_d   = lat_q;
      out_d   = out_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      to_d    = to_q;
      sel     = 1'b0;

      // A request is only captured into an empty slot; repeats while pending are dropped.
      for (int m = 0; m < 2; m++) begin
        if (req_in[c][m] && !pend_q[m]) begin
          pend_d[m] = 1'b1;
          lat_d[m]  = pay_in[c][m];
        end
      end

      unique case (state_q)
        StIdle: begin
          if (|pend_q) begin
            sel         = (pend_q == 2'b11) ? ~last_q : pend_q[1];
            gnt_d       = sel;
            last_d      = sel;
            pend_d[sel] = 1'b0;
            out_d       = lat_q[sel];
            state_d     = StIssue;
          end
        end
        StIssue: begin
          cnt_d   = '0;
          to_d    = 1'b0;
          state_d = bank_ack[c] ? StResp : StWait;
        end
        StWait: begin
          if (bank_ack[c]) begin
            state_d = StResp;
          end else if (cnt_q == ToLast) begin
            to_d    = 1'b1;
            state_d = StResp;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        StResp: begin
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
        state_q <= StIdle;
        pend_q  <= '0;
        lat_q   <= '{default: '0};
        out_q   <= '0;
        gnt_q   <= 1'b0;
        last_q  <= 1'b1;
        cnt_q   <= '0;
        to_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        pend_q  <= pend_d;
        lat_q   <= lat_d;
        out_q   <= out_d;
        gnt_q   <= gnt_d;
        last_q  <= last_d;
        cnt_q   <= cnt_d;
        to_q    <= to_d;
      end
    end

    assign up_req[c]     = (state_q == StIssue);
    assign m_ack[c]      = (state_q != StResp) ? 2'b00 : (gnt_q ? 2'b10 : 2'b01);
    assign timeout[c]    = (state_q == StResp) && to_q;
    assign pay_out[c]    = out_q;
    assign resp_enter[c] = (state_q != StResp) && (state_d == StResp);
    assign resp_to[c]    = to_d;
    assign gnt[c]        = gnt_q;
  end

  // Read data is captured on the edge into RESP and then held until that master's next response.
  logic [DW-1:0] rd_dout_q [2];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_dout_q <= '{default: '0};
    end else if (resp_enter[1]) begin
      rd_dout_q[gnt[1]] <= resp_to[1] ? {DW{1'b1}} : bus.up_rd_dout;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{pay_out[1][PW-AW-1:0], resp_enter[0], resp_to[0], gnt[0]};

  assign bus.up_wr_req                             = up_req[0];
  assign {bus.up_wr_addr, bus.up_wr_be, bus.up_wr_din} = pay_out[0];
  assign bus.up_rd_req                             = up_req[1];
  assign bus.up_rd_addr                            = pay_out[1][PW-1 -: AW];

  assign bus.m0_up_wr_ack  = m_ack[0][0];
  assign bus.m1_up_wr_ack  = m_ack[0][1];
  assign bus.m0_up_rd_ack  = m_ack[1][0];
  assign bus.m1_up_rd_ack  = m_ack[1][1];
  assign bus.m0_up_rd_dout = rd_dout_q[0];
  assign bus.m1_up_rd_dout = rd_dout_q[1];

  assign bus.wr_timeout = timeout[0];
  assign bus.rd_timeout = timeout[1];
endmodule
